// File: rtl/rand_word_collector.sv
// rtl/rand_word_collector.sv - TRNG byte-stream collector; RDRAND/RDSEED word assembly with inter-byte timeout.
// Optional statistics counters under `ifdef RAND_COLLECT_STATS_EN.
package le_types;
   typedef enum logic [1:0] {
      RDRAND_32 = 2'd0,
      RDRAND_64 = 2'd1,
      RDSEED_32 = 2'd2,
      RDSEED_64 = 2'd3
   } rand_req_t;
endpackage

module rand_word_collector
   import le_types::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        ic_clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_seed,
   input  logic        cmd_64,
   output logic        rand_req,
   output rand_req_t   rand_req_type,
   input  logic [7:0]  rand_byte,
   input  logic        rand_valid,
   output logic        word_valid,
   input  logic        word_ready,
   output logic [63:0] word_data,
   output logic        word_is_seed,
   output logic        timeout_err
`ifdef RAND_COLLECT_STATS_EN
   ,
   output logic [15:0] stat_words,
   output logic [7:0]  stat_timeouts,
   output logic [7:0]  stat_stray
`endif
);

   localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

   state_t                state_q, state_d;
   logic [2:0]            byte_cnt_q, byte_cnt_d;
   logic [TIMEOUT_W-1:0]  tcnt_q, tcnt_d;
   logic [63:0]           word_data_q, word_data_d;
   logic                  seed_q, seed_d;
   logic                  w64_q, w64_d;
   logic                  rand_req_q, rand_req_d;
   rand_req_t             rand_req_type_q, rand_req_type_d;
   logic                  word_valid_q, word_valid_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  timeout_err_q, timeout_err_d;

   always_comb begin
      state_d         = state_q;
      byte_cnt_d      = byte_cnt_q;
      tcnt_d          = tcnt_q;
      word_data_d     = word_data_q;
      seed_d          = seed_q;
      w64_d           = w64_q;
      rand_req_d      = rand_req_q;
      rand_req_type_d = rand_req_type_q;
      word_valid_d    = word_valid_q;
      cmd_ready_d     = cmd_ready_q;
      timeout_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d         = S_COLLECT;
               seed_d          = cmd_seed;
               w64_d           = cmd_64;
               byte_cnt_d      = 3'd0;
               tcnt_d          = '0;
               word_data_d     = 64'd0;
               rand_req_d      = 1'b1;
               rand_req_type_d = rand_req_t'({cmd_seed, cmd_64});
               cmd_ready_d     = 1'b0;
            end
         end
         S_COLLECT: begin
            // A byte on the limit cycle takes priority over the abort.
            if (rand_valid) begin
               word_data_d[{byte_cnt_q, 3'b000} +: 8] = rand_byte;
               byte_cnt_d = byte_cnt_q + 3'd1;
               tcnt_d     = '0;
               if (byte_cnt_q == (w64_q ? 3'd7 : 3'd3)) begin
                  state_d      = S_HOLD;
                  rand_req_d   = 1'b0;
                  word_valid_d = 1'b1;
               end
            end else if (tcnt_q == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
               state_d       = S_IDLE;
               rand_req_d    = 1'b0;
               timeout_err_d = 1'b1;
               cmd_ready_d   = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (word_ready) begin
               state_d      = S_IDLE;
               word_valid_d = 1'b0;
               cmd_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            rand_req_d  = 1'b0;
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge ic_clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         byte_cnt_q      <= 3'd0;
         tcnt_q          <= '0;
         word_data_q     <= 64'd0;
         seed_q          <= 1'b0;
         w64_q           <= 1'b0;
         rand_req_q      <= 1'b0;
         rand_req_type_q <= RDRAND_32;
         word_valid_q    <= 1'b0;
         cmd_ready_q     <= 1'b1;
         timeout_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         byte_cnt_q      <= byte_cnt_d;
         tcnt_q          <= tcnt_d;
         word_data_q     <= word_data_d;
         seed_q          <= seed_d;
         w64_q           <= w64_d;
         rand_req_q      <= rand_req_d;
         rand_req_type_q <= rand_req_type_d;
         word_valid_q    <= word_valid_d;
         cmd_ready_q     <= cmd_ready_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rand_req      = rand_req_q;
   assign rand_req_type = rand_req_type_q;
   assign word_valid    = word_valid_q;
   assign word_data     = word_data_q;
   assign word_is_seed  = seed_q;
   assign timeout_err   = timeout_err_q;

`ifdef RAND_COLLECT_STATS_EN
   logic [15:0] stat_words_q, stat_words_d;
   logic [7:0]  stat_timeouts_q, stat_timeouts_d;
   logic [7:0]  stat_stray_q, stat_stray_d;

   always_comb begin
      stat_words_d    = stat_words_q;
      stat_timeouts_d = stat_timeouts_q;
      stat_stray_d    = stat_stray_q;
      if (state_q == S_HOLD && word_ready)
         stat_words_d = stat_words_q + 16'd1;
      if (timeout_err_d && stat_timeouts_q != 8'hFF)
         stat_timeouts_d = stat_timeouts_q + 8'd1;
      if (rand_valid && state_q != S_COLLECT && stat_stray_q != 8'hFF)
         stat_stray_d = stat_stray_q + 8'd1;
   end

   always_ff @(posedge ic_clk or posedge rst) begin
      if (rst) begin
         stat_words_q    <= 16'd0;
         stat_timeouts_q <= 8'd0;
         stat_stray_q    <= 8'd0;
      end else begin
         stat_words_q    <= stat_words_d;
         stat_timeouts_q <= stat_timeouts_d;
         stat_stray_q    <= stat_stray_d;
      end
   end

   assign stat_words    = stat_words_q;
   assign stat_timeouts = stat_timeouts_q;
   assign stat_stray    = stat_stray_q;
`endif

endmodule

// File: tb/tb_rand_word_collector.sv
// tb/tb_rand_word_collector.sv - randomized self-checking bench for rand_word_collector.
// Statistics ports checked when RAND_COLLECT_STATS_EN is defined.
module tb_rand_word_collector;
   import le_types::*;

   localparam int TO = 16;

   logic        ic_clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_seed = 1'b0;
   logic        cmd_64 = 1'b0;
   logic        rand_req;
   rand_req_t   rand_req_type;
   logic [7:0]  rand_byte = 8'd0;
   logic        rand_valid = 1'b0;
   logic        word_valid;
   logic        word_ready = 1'b0;
   logic [63:0] word_data;
   logic        word_is_seed;
   logic        timeout_err;
`ifdef RAND_COLLECT_STATS_EN
   logic [15:0] stat_words;
   logic [7:0]  stat_timeouts;
   logic [7:0]  stat_stray;
`endif

   int checks = 0;
   int failures = 0;
   int n_words = 0;
   int n_tmo = 0;
   int n_stray = 0;

   rand_word_collector #(.TIMEOUT_CYCLES(TO)) dut (
      .ic_clk(ic_clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_seed(cmd_seed), .cmd_64(cmd_64),
      .rand_req(rand_req), .rand_req_type(rand_req_type),
      .rand_byte(rand_byte), .rand_valid(rand_valid),
      .word_valid(word_valid), .word_ready(word_ready),
      .word_data(word_data), .word_is_seed(word_is_seed),
      .timeout_err(timeout_err)
`ifdef RAND_COLLECT_STATS_EN
      , .stat_words(stat_words), .stat_timeouts(stat_timeouts), .stat_stray(stat_stray)
`endif
   );

   always #5 ic_clk = ~ic_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ic_clk);
      #1;
   endtask

   function automatic rand_req_t expected_type(input bit seed, input bit w64);
      if (seed) return w64 ? RDSEED_64 : RDSEED_32;
      return w64 ? RDRAND_64 : RDRAND_32;
   endfunction

   task automatic check_stats();
`ifdef RAND_COLLECT_STATS_EN
      check("stat_words", 64'(stat_words), 64'(n_words % 65536));
      check("stat_timeouts", 64'(stat_timeouts), 64'(n_tmo > 255 ? 255 : n_tmo));
      check("stat_stray", 64'(stat_stray), 64'(n_stray > 255 ? 255 : n_stray));
`endif
   endtask

   // gap < 0 draws each inter-byte gap at random in 0..TO (TO is the exact limit).
   task automatic collect(input bit seed, input bit w64, input logic [63:0] fixed,
                          input bit use_fixed, input int gap, input int hold, input bit strays);
      int n;
      int g;
      logic [63:0] exp_word;
      logic [7:0] b;
      n = w64 ? 8 : 4;
      exp_word = 64'd0;
      check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_seed = seed; cmd_64 = w64;
      tick();
      cmd_valid = 1'b0; cmd_seed = 1'($urandom); cmd_64 = 1'($urandom);
      check("req_up", 64'(rand_req), 64'd1);
      check("req_type", 64'(rand_req_type), 64'(expected_type(seed, w64)));
      check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      for (int i = 0; i < n; i++) begin
         g = (gap < 0) ? int'($urandom_range(0, TO)) : gap;
         for (int k = 0; k < g; k++) begin
            tick();
            check("req_hold", 64'(rand_req), 64'd1);
            check("no_word_yet", 64'(word_valid), 64'd0);
            check("no_tmo_gap", 64'(timeout_err), 64'd0);
         end
         b = use_fixed ? fixed[8*i +: 8] : 8'($urandom);
         exp_word[8*i +: 8] = b;
         rand_valid = 1'b1; rand_byte = b;
         tick();
         rand_valid = 1'b0; rand_byte = 8'($urandom);
         check("no_tmo_byte", 64'(timeout_err), 64'd0);
      end
      check("req_drop", 64'(rand_req), 64'd0);
      check("word_valid_up", 64'(word_valid), 64'd1);
      check("word_data", word_data, exp_word);
      check("word_is_seed", 64'(word_is_seed), 64'(seed));
      for (int k = 0; k < hold; k++) begin
         if (strays && $urandom_range(0, 1) == 1) begin
            rand_valid = 1'b1; rand_byte = 8'($urandom);
            n_stray++;
         end
         tick();
         rand_valid = 1'b0;
         check("hold_data", word_data, exp_word);
         check("hold_valid", 64'(word_valid), 64'd1);
         check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      n_words++;
      check("word_taken", 64'(word_valid), 64'd0);
      check("cmd_ready_back", 64'(cmd_ready), 64'd1);
      check_stats();
   endtask

   task automatic timeout_run(input int nbytes);
      int seen;
      seen = -1;
      cmd_valid = 1'b1; cmd_seed = 1'b0; cmd_64 = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < nbytes; i++) begin
         rand_valid = 1'b1; rand_byte = 8'($urandom);
         tick();
         rand_valid = 1'b0;
      end
      for (int k = 1; k <= TO + 4; k++) begin
         tick();
         if (word_valid) check("tmo_no_word", 64'(word_valid), 64'd0);
         if (timeout_err && seen < 0) begin
            seen = k;
            check("tmo_cmd_ready", 64'(cmd_ready), 64'd1);
            check("tmo_req_drop", 64'(rand_req), 64'd0);
         end else if (seen > 0 && k == seen + 1) begin
            check("tmo_one_cycle", 64'(timeout_err), 64'd0);
         end
      end
      n_tmo++;
      // Source silent for TO cycles after the last byte, abort seen one cycle later.
      check("tmo_cycle", 64'(seen), 64'(TO + 1));
      check("tmo_word_off", 64'(word_valid), 64'd0);
      check_stats();
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_rand_req", 64'(rand_req), 64'd0);
      check("rst_req_type", 64'(rand_req_type), 64'(RDRAND_32));
      check("rst_word_valid", 64'(word_valid), 64'd0);
      check("rst_word_data", word_data, 64'd0);
      check("rst_is_seed", 64'(word_is_seed), 64'd0);
      check("rst_tmo", 64'(timeout_err), 64'd0);
      check_stats();

      rand_valid = 1'b1; rand_byte = 8'h5A;
      tick();
      rand_valid = 1'b0;
      n_stray++;
      check("idle_stray_ready", 64'(cmd_ready), 64'd1);
      check("idle_stray_req", 64'(rand_req), 64'd0);

      collect(1'b1, 1'b1, 64'h0807060504030201, 1'b1, 0, 20, 1'b1);
      collect(1'b0, 1'b0, 64'h00000000DDCCBBAA, 1'b1, 5, 3, 1'b0);
      timeout_run(2);
      collect(1'b0, 1'b1, 64'd0, 1'b0, TO, 2, 1'b0);
      timeout_run(0);
      for (int t = 0; t < 6; t++)
         collect(1'($urandom), 1'($urandom), 64'd0, 1'b0, -1, int'($urandom_range(0, 6)), 1'b1);

      cmd_valid = 1'b1; cmd_seed = 1'b1; cmd_64 = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_valid = 1'b1; rand_byte = 8'($urandom);
         tick();
         rand_valid = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      check("async_rst_req", 64'(rand_req), 64'd0);
      check("async_rst_valid", 64'(word_valid), 64'd0);
      tick();
      rst = 1'b0;
      n_words = 0; n_tmo = 0; n_stray = 0;
      tick();
      check("post_rst_ready", 64'(cmd_ready), 64'd1);
      check("post_rst_req", 64'(rand_req), 64'd0);
      check_stats();
      collect(1'b1, 1'b1, 64'd0, 1'b0, -1, 2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
